// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator data movers: FSM state
// encodings and default bus/dimension widths.
package cnn_pkg;

  localparam int DATA_SIZE     = 8;
  localparam int ARRAY_SIZE    = 9;
  localparam int DIM_DATA_SIZE = 8;
  localparam int ADDR_SIZE     = 20;

  // Encodings are visible on the debug state port, so the values are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    CHECK = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_control_if.sv
// Bus bundle between the drain controller, the output FIFO bank (pop strobes,
// empty flags, shared read data) and the feature-map memory write port.
interface fifo_drain_control_if import cnn_pkg::*; #(
  parameter int data_size  = DATA_SIZE,
  parameter int array_size = ARRAY_SIZE,
  parameter int addr_size  = ADDR_SIZE
) ();

  logic [array_size-1:0] fifo_empty;
  logic [data_size-1:0]  bus_in;
  logic [array_size-1:0] read_enable_out;
  logic [addr_size-1:0]  mem_address;
  logic [data_size-1:0]  mem_data;
  logic                  mem_write;

  // The controller side: consumes FIFO status/data, drives pops and writes.
  modport master (
    input  fifo_empty,
    input  bus_in,
    output read_enable_out,
    output mem_address,
    output mem_data,
    output mem_write
  );

  // The FIFO bank / memory side.
  modport slave (
    output fifo_empty,
    output bus_in,
    input  read_enable_out,
    input  mem_address,
    input  mem_data,
    input  mem_write
  );

endinterface

// File: rtl/drain_position_counter.sv
// Row/column walker for the row-major drain, plus a running write address
// that steps by one per element so no multiplier is needed.
module drain_position_counter import cnn_pkg::*; #(
  parameter int dim_size  = DIM_DATA_SIZE + 1,
  parameter int addr_size = ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [dim_size-1:0]  ow,
  input  logic [dim_size-1:0]  oh,
  input  logic [addr_size-1:0] initial_address,
  output logic [dim_size-1:0]  c,
  output logic [addr_size-1:0] address,
  output logic                 last
);

  localparam logic [dim_size-1:0] ONE = dim_size'(1);

  logic [dim_size-1:0]  r_reg;
  logic [dim_size-1:0]  c_reg;
  logic [addr_size-1:0] address_reg;
  logic                 col_last;

  assign col_last = (c_reg == ow - ONE);
  assign last     = col_last && (r_reg == oh - ONE);
  assign c        = c_reg;
  assign address  = address_reg;

  // Clear loads the base address; each advance steps column, wrapping into the next row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg       <= '0;
      c_reg       <= '0;
      address_reg <= '0;
    end else if (clear) begin
      r_reg       <= '0;
      c_reg       <= '0;
      address_reg <= initial_address;
    end else if (advance) begin
      address_reg <= address_reg + addr_size'(1);
      if (col_last) begin
        c_reg <= '0;
        r_reg <= r_reg + ONE;
      end else begin
        c_reg <= c_reg + ONE;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_control.sv
// Drains convolution results from the per-column output FIFOs one element at
// a time (CHECK -> READ -> WRITE) and writes them row-major from a base address.
module fifo_drain_control import cnn_pkg::*; #(
  parameter int data_size     = DATA_SIZE,
  parameter int array_size    = ARRAY_SIZE,
  parameter int dim_data_size = DIM_DATA_SIZE,
  parameter int addr_size     = ADDR_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [addr_size-1:0]     initial_address,
  input  logic [dim_data_size-1:0] weight_size,
  input  logic [dim_data_size-1:0] image_height,
  input  logic [dim_data_size-1:0] image_width,
  fifo_drain_control_if.master     bus,
  output logic [2:0]               state,
  output logic                     done
);

  // One extra bit so K > H / K > W / OW > array_size cannot hide behind a wrap.
  localparam int DW = dim_data_size + 1;
  localparam logic [DW-1:0] ARRAY_LIMIT = DW'(array_size);
  localparam logic [DW-1:0] ONE         = DW'(1);

  drain_state_t state_reg, state_next;

  logic [DW-1:0] k_ext, h_ext, w_ext;
  logic [DW-1:0] ow_calc, oh_calc;
  logic          config_invalid;

  logic [DW-1:0] ow_reg, oh_reg;
  logic [data_size-1:0] data_reg;
  logic [addr_size-1:0] mem_address_reg;

  logic                  clear, advance;
  logic [DW-1:0]         col;
  logic [addr_size-1:0]  address;
  logic                  last;
  logic [array_size-1:0] col_sel;
  logic [array_size-1:0] pop_sel;
  logic                  empty_at_col;

  assign k_ext   = {1'b0, weight_size};
  assign h_ext   = {1'b0, image_height};
  assign w_ext   = {1'b0, image_width};
  assign ow_calc = w_ext - k_ext + ONE;
  assign oh_calc = h_ext - k_ext + ONE;

  // K > W is tested before ow_calc is trusted, so its possible wrap is harmless.
  assign config_invalid = (k_ext == '0) || (k_ext > h_ext) || (k_ext > w_ext) ||
                          (ow_calc > ARRAY_LIMIT);

  drain_position_counter #(
    .dim_size  (DW),
    .addr_size (addr_size)
  ) u_position (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .advance         (advance),
    .ow              (ow_reg),
    .oh              (oh_reg),
    .initial_address (initial_address),
    .c               (col),
    .address         (address),
    .last            (last)
  );

  // One-hot decode of the current column; columns >= OW are never selected
  // because the counter wraps at OW.
  generate
    for (genvar gi = 0; gi < array_size; gi++) begin : g_col_sel
      assign col_sel[gi] = (col == DW'(gi));
    end
  endgenerate

  assign empty_at_col = |(bus.fifo_empty & col_sel);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-state strobes; the pop is gated by the live
  // empty flag so a pop never coincides with an empty FIFO.
  always_comb begin
    state_next = state_reg;
    pop_sel    = '0;
    clear      = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = CALC;
      end
      CALC: begin
        clear      = 1'b1;
        state_next = config_invalid ? DONE : CHECK;
      end
      CHECK: begin
        if (!empty_at_col) begin
          pop_sel    = col_sel;
          state_next = READ;
        end
      end
      READ: begin
        state_next = WRITE;
      end
      WRITE: begin
        advance    = 1'b1;
        state_next = last ? DONE : CHECK;
      end
      DONE: begin
        if (!enable) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output dimensions are captured once per job so mid-drain input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ow_reg <= '0;
      oh_reg <= '0;
    end else if (state_reg == CALC) begin
      ow_reg <= ow_calc;
      oh_reg <= oh_calc;
    end
  end

  // Popped data arrives one cycle after the pop; capture it with its address
  // so both stay stable through the write and until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg        <= '0;
      mem_address_reg <= '0;
    end else if (state_reg == READ) begin
      data_reg        <= bus.bus_in;
      mem_address_reg <= address;
    end
  end

  assign bus.read_enable_out = pop_sel;
  assign bus.mem_write       = (state_reg == WRITE);
  assign bus.mem_address     = mem_address_reg;
  assign bus.mem_data        = data_reg;
  assign done                = (state_reg == DONE);
  assign state               = state_reg;

endmodule

// File: tb/tb_fifo_drain_control.sv
// Directed bench for fifo_drain_control: a FIFO bank model feeds 10*c + row,
// expected writes go into a queue and a negedge monitor pops and compares.
module tb_fifo_drain_control;
  import cnn_pkg::*;

  localparam int DS  = 8;
  localparam int AS  = 9;
  localparam int DIM = 8;
  localparam int ADR = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           enable;
  logic [ADR-1:0] initial_address;
  logic [DIM-1:0] weight_size, image_height, image_width;
  logic [2:0]     state;
  logic           done;

  fifo_drain_control_if #(.data_size(DS), .array_size(AS), .addr_size(ADR)) bif ();

  fifo_drain_control #(
    .data_size(DS), .array_size(AS), .dim_data_size(DIM), .addr_size(ADR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .initial_address (initial_address),
    .weight_size     (weight_size),
    .image_height    (image_height),
    .image_width     (image_width),
    .bus             (bif),
    .state           (state),
    .done            (done)
  );

  typedef struct {
    logic [ADR-1:0] addr;
    logic [DS-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  assertions = 0;
  int  failures   = 0;
  int  pop_seen   = 0;
  logic model_clear = 1'b0;
  int unsigned pop_cnt[AS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO bank model: FIFO c yields 10*c + (number of earlier pops of c), one cycle after the pop.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < AS; i++) pop_cnt[i] <= 0;
      bif.bus_in <= '0;
    end else if (model_clear) begin
      for (int i = 0; i < AS; i++) pop_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < AS; i++) begin
        if (bif.read_enable_out[i]) begin
          bif.bus_in <= DS'(10 * i + int'(pop_cnt[i]));
          pop_cnt[i] <= pop_cnt[i] + 1;
        end
      end
    end
  end

  // Monitor: pop protocol and scoreboard comparison of every memory write.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bif.read_enable_out != '0) begin
        pop_seen++;
        assertions++;
        if (!$onehot(bif.read_enable_out) || ((bif.read_enable_out & bif.fifo_empty) != '0)) begin
          failures++;
          $display("FAIL pop_protocol: got re=%b empty=%b required one-hot pop of a non-empty FIFO",
                   bif.read_enable_out, bif.fifo_empty);
        end
      end
      if (bif.mem_write === 1'b1) begin
        assertions++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%h data=%h required no write",
                   bif.mem_address, bif.mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bif.mem_address !== mon_e.addr || bif.mem_data !== mon_e.data) begin
            failures++;
            $display("FAIL write_compare: got addr=%h data=%h required addr=%h data=%h",
                     bif.mem_address, bif.mem_data, mon_e.addr, mon_e.data);
          end else begin
            $display("write addr=%h data=%0d", bif.mem_address, bif.mem_data);
          end
        end
      end
    end
  end

  // One drain job: stall holds FIFO 1 empty during its first CHECK;
  // abort pulls reset low during the third WRITE.
  task automatic run_drain(input int h, input int w, input int k, input int base,
                           input bit stall, input bit abort);
    int  ow, oh, n_el, n, p0, exp_lat;
    bit  valid, got_done;
    logic [31:0] a32;
    ow    = w - k + 1;
    oh    = h - k + 1;
    valid = (k != 0) && (k <= h) && (k <= w) && (ow <= AS);
    n_el  = valid ? ow * oh : 0;
    if (valid) begin
      for (int r = 0; r < oh; r++) begin
        for (int c = 0; c < ow; c++) begin
          wr_t e;
          a32    = 32'(base + r * ow + c);
          e.addr = a32[ADR-1:0];
          e.data = DS'(10 * c + r);
          exp_q.push_back(e);
        end
      end
    end
    $display("job H=%0d W=%0d K=%0d base=%h stall=%0d abort=%0d", h, w, k, base, stall, abort);
    p0 = pop_seen;
    @(negedge clk);
    #1;
    image_height    = DIM'(h);
    image_width     = DIM'(w);
    weight_size     = DIM'(k);
    initial_address = ADR'(base);
    bif.fifo_empty  = stall ? AS'(2) : '0;
    model_clear     = 1'b1;
    enable          = 1'b1;
    reset           = 1'b1;
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      model_clear = 1'b0;
      if (valid && !stall && n == 4) chk("first_write_cycle", bif.mem_write, 1);
      if (stall && n >= 5 && n <= 9) begin
        chk("stall_state", state, 2);
        chk("stall_no_pop", bif.read_enable_out, 0);
        if (n == 9) begin
          #1 bif.fifo_empty = '0;
        end
      end
      if (stall && n == 10) chk("stall_pop_then_read", state, 3);
      if (abort && n == 10) begin
        chk("third_write_state", state, 4);
        #1 reset = 1'b0;
        #1;
        chk("rst_read_enable", bif.read_enable_out, 0);
        chk("rst_mem_write", bif.mem_write, 0);
        chk("rst_mem_address", bif.mem_address, 0);
        chk("rst_mem_data", bif.mem_data, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state, 0);
        exp_q.delete();
        return;
      end
      if (done === 1'b1) got_done = 1'b1;
    end
    exp_lat = valid ? (3 * n_el + 2 + (stall ? 4 : 0)) : 2;
    chk("done_latency", n, exp_lat);
    chk("all_writes_seen", exp_q.size(), 0);
    if (!valid) chk("no_pops_invalid", pop_seen - p0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("done_held", done, 1);
    end
    #1 enable = 1'b0;
    @(negedge clk);
    chk("idle_after_release", state, 0);
    chk("done_low_after_release", done, 0);
  endtask

  initial begin
    reset           = 1'b0;
    enable          = 1'b0;
    initial_address = '0;
    weight_size     = '0;
    image_height    = '0;
    image_width     = '0;
    bif.fifo_empty  = '0;

    @(negedge clk);
    #1;
    chk("reset_read_enable", bif.read_enable_out, 0);
    chk("reset_mem_write", bif.mem_write, 0);
    chk("reset_mem_address", bif.mem_address, 0);
    chk("reset_mem_data", bif.mem_data, 0);
    chk("reset_done", done, 0);
    chk("reset_state", state, 0);

    run_drain(5, 5, 3, 0, 1'b0, 1'b0);          // nominal
    run_drain(5, 5, 3, 'h100, 1'b1, 1'b0);      // stall on column 1
    run_drain(4, 4, 3, 'hFFFFE, 1'b0, 1'b0);    // address wrap
    run_drain(5, 5, 6, 0, 1'b0, 1'b0);          // K > H
    run_drain(5, 5, 0, 0, 1'b0, 1'b0);          // K = 0
    run_drain(5, 12, 2, 0, 1'b0, 1'b0);         // OW = 11 > 9
    run_drain(5, 5, 3, 'h40, 1'b0, 1'b1);       // reset mid-drain
    run_drain(5, 5, 3, 'h40, 1'b0, 1'b0);       // full restart after reset

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
